// File: rtl/mdu_iterative_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and small op-decode helpers used by the top level and the step datapath.
package mdu_iterative_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    function automatic logic op_is_div(input mdu_op_e o);
        case (o)
            MDU_DIV, MDU_DIVU: op_is_div = 1'b1;
            default:           op_is_div = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_signed(input mdu_op_e o);
        case (o)
            MDU_MULT, MDU_DIV: op_is_signed = 1'b1;
            default:           op_is_signed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_iterative_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// The partial value is {upper[WIDTH:0], lower[WIDTH-1:0]}; divide leaves lower[0] for the quotient bit.
module mdu_step
    import mdu_iterative_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               mode,
    input  logic [2*WIDTH:0]   part,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   next_part,
    output logic               q_bit
);

    logic [WIDTH:0]   upper_s;
    logic [WIDTH-1:0] lower_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH+1:0] diff_s;

    assign upper_s = part[2*WIDTH:WIDTH];
    assign lower_s = part[WIDTH-1:0];
    assign sum_s   = upper_s + {1'b0, operand};
    assign shl_s   = {upper_s[WIDTH-1:0], lower_s[WIDTH-1]};
    // Extra top bit is the borrow: set means the trial subtraction went negative.
    assign diff_s  = {1'b0, shl_s} - {2'b00, operand};

    // Select the next partial value for the current mode.
    always_comb begin
        next_part = {(2*WIDTH+1){1'b0}};
        q_bit     = 1'b0;
        if (mode == MODE_DIV) begin
            q_bit = ~diff_s[WIDTH+1];
            if (q_bit) begin
                next_part = {diff_s[WIDTH:0], lower_s[WIDTH-2:0], 1'b0};
            end else begin
                next_part = {shl_s, lower_s[WIDTH-2:0], 1'b0};
            end
        end else begin
            q_bit = lower_s[0];
            if (lower_s[0]) begin
                next_part = {1'b0, sum_s, lower_s[WIDTH-1:1]};
            end else begin
                next_part = {1'b0, upper_s, lower_s[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Magnitudes are iterated WIDTH times, then a separate cycle applies the sign fix before commit.
module mdu_iterative
    import mdu_iterative_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e       state_r, state_s;
    logic             accept_s, commit_s;
    logic [CNT_W-1:0] cnt_r;
    logic             fix_stage_r;
    mdu_op_e          op_r;
    logic [2*WIDTH:0] part_r, step_part_s;
    logic [WIDTH-1:0] operand_r;
    logic             q_bit_s, mode_s;
    logic             q_neg_r, r_neg_r, dz_r;
    logic [WIDTH-1:0] res_hi_r, res_lo_r;
    logic [WIDTH-1:0] fix_hi_s, fix_lo_s;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             busy_r, done_r;

    logic             in_div_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0] abs_a_s, abs_b_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic [WIDTH-1:0] quo_s, rem_s;

    assign accept_s = start & ~busy_r & ~flush;
    assign in_div_s = op_is_div(mdu_op_e'(op));
    assign a_neg_s  = op_is_signed(mdu_op_e'(op)) & A[WIDTH-1];
    assign b_neg_s  = op_is_signed(mdu_op_e'(op)) & B[WIDTH-1];
    assign abs_a_s  = a_neg_s ? (~A + {{(WIDTH-1){1'b0}}, 1'b1}) : A;
    assign abs_b_s  = b_neg_s ? (~B + {{(WIDTH-1){1'b0}}, 1'b1}) : B;
    assign mode_s   = op_is_div(op_r) ? MODE_DIV : MODE_MUL;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .mode      (mode_s),
        .part      (part_r),
        .operand   (operand_r),
        .next_part (step_part_s),
        .q_bit     (q_bit_s)
    );

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= MDU_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; commit marks the cycle that writes HI/LO and raises done.
    always_comb begin
        state_s  = state_r;
        commit_s = 1'b0;
        case (state_r)
            MDU_IDLE: begin
                if (accept_s) begin
                    state_s = MDU_RUN;
                end else begin
                    state_s = MDU_IDLE;
                end
            end
            MDU_RUN: begin
                if (flush) begin
                    state_s = MDU_IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    state_s = MDU_FIX;
                end else begin
                    state_s = MDU_RUN;
                end
            end
            MDU_FIX: begin
                if (flush) begin
                    state_s = MDU_IDLE;
                end else if (fix_stage_r) begin
                    state_s  = MDU_IDLE;
                    commit_s = 1'b1;
                end else begin
                    state_s = MDU_FIX;
                end
            end
            default: begin
                state_s = MDU_IDLE;
            end
        endcase
    end

    assign prod_s     = part_r[2*WIDTH-1:0];
    assign prod_fix_s = q_neg_r ? (~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_s;
    assign quo_s      = part_r[WIDTH-1:0];
    assign rem_s      = part_r[2*WIDTH-1:WIDTH];

    // Sign correction of the magnitude result; divide by zero forces an all-ones quotient.
    always_comb begin
        fix_hi_s = {WIDTH{1'b0}};
        fix_lo_s = {WIDTH{1'b0}};
        if (op_is_div(op_r)) begin
            fix_hi_s = r_neg_r ? (~rem_s + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_s;
            if (dz_r) begin
                fix_lo_s = {WIDTH{1'b1}};
            end else if (q_neg_r) begin
                fix_lo_s = ~quo_s + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                fix_lo_s = quo_s;
            end
        end else begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Operand capture, iteration and sign-fix staging.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            fix_stage_r <= 1'b0;
            op_r        <= MDU_MULT;
            part_r      <= {(2*WIDTH+1){1'b0}};
            operand_r   <= {WIDTH{1'b0}};
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            dz_r        <= 1'b0;
            res_hi_r    <= {WIDTH{1'b0}};
            res_lo_r    <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    fix_stage_r <= 1'b0;
                    if (accept_s) begin
                        op_r      <= mdu_op_e'(op);
                        cnt_r     <= CNT_W'(WIDTH);
                        operand_r <= in_div_s ? abs_b_s : abs_a_s;
                        part_r    <= {{(WIDTH+1){1'b0}}, (in_div_s ? abs_a_s : abs_b_s)};
                        q_neg_r   <= a_neg_s ^ b_neg_s;
                        r_neg_r   <= a_neg_s;
                        dz_r      <= in_div_s & (B == {WIDTH{1'b0}});
                    end
                end
                MDU_RUN: begin
                    if (flush) begin
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        part_r <= {step_part_s[2*WIDTH:1],
                                   (mode_s == MODE_DIV) ? q_bit_s : step_part_s[0]};
                        cnt_r  <= cnt_r - CNT_W'(1);
                    end
                end
                MDU_FIX: begin
                    if (flush) begin
                        fix_stage_r <= 1'b0;
                    end else if (!fix_stage_r) begin
                        res_hi_r    <= fix_hi_s;
                        res_lo_r    <= fix_lo_s;
                        fix_stage_r <= 1'b1;
                    end else begin
                        fix_stage_r <= 1'b0;
                    end
                end
                default: begin
                    fix_stage_r <= 1'b0;
                end
            endcase
        end
    end

    // Architectural HI/LO plus registered busy/done; MTHI/MTLO only land while idle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != MDU_IDLE);
            done_r <= commit_s;
            if (commit_s) begin
                hi_r <= res_hi_r;
                lo_r <= res_lo_r;
            end else if (!busy_r) begin
                if (hi_we) begin
                    hi_r <= wdata;
                end
                if (lo_we) begin
                    lo_r <= wdata;
                end
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed, table-driven bench for mdu_iterative at WIDTH=32, with hand-built
// sequences for flush, MTHI/MTLO interaction and mid-operation reset.
module tb_mdu_iterative;

    logic        Clock = 1'b0;
    logic        Reset, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] A, B, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_bad = 0;

    mdu_iterative #(.WIDTH(32)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        string       name;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one op from idle and wait (bounded) for busy to drop; returns busy cycle count.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic [31:0] wd, output int bcnt);
        op = o; A = a; B = b; start = 1'b1;
        lo_we = we; wdata = wd;
        @(posedge Clock); #1;
        start = 1'b0; lo_we = 1'b0;
        check("done_low_after_accept", done, 0);
        if (we) check("lo_we_with_start", lo, wd);
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 100) begin
            bcnt++;
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc;
        int dcnt;
        int bsy;

        vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[1]  = '{2'd0, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg7x3"};
        vecs[2]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin"};
        vecs[3]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2"};
        vecs[4]  = '{2'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, "divu_7by2"};
        vecs[5]  = '{2'd2, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, "div_by_zero"};
        vecs[6]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"};
        vecs[7]  = '{2'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_7xneg3"};
        vecs[8]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7byneg2"};
        vecs[9]  = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_max_by16"};
        vecs[10] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by_zero"};
        vecs[11] = '{2'd1, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, "multu_by_zero"};
        vecs[12] = '{2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, "mult_maxpos"};
        vecs[13] = '{2'd3, 32'h00000005, 32'h00000007, 32'h00000005, 32'h00000000, "divu_small"};
        vecs[14] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_neg1xneg1"};

        Reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd0; A = 32'h0; B = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        Reset = 1'b0;

        // flush in idle blocks a simultaneous start
        op = 2'd1; A = 32'd3; B = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_blocks_start", busy, 0);

        // table: each op starts in the done cycle of the previous one
        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 32'h0, bc);
            check({vecs[i].name, "_busy_cycles"}, bc, 34);
            check({vecs[i].name, "_done"}, done, 1);
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
        end

        // MTHI, then flush a running MULTU after ignored start/hi_we
        hi_we = 1'b1; wdata = 32'hAAAA5555;
        @(posedge Clock); #1;
        hi_we = 1'b0;
        check("mthi", hi, 32'hAAAA5555);
        op = 2'd1; A = 32'd3; B = 32'd5; start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        check("flush_op_busy", busy, 1);
        repeat (9) @(posedge Clock);
        #1;
        op = 2'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'h0BADF00D;
        @(posedge Clock); #1;
        start = 1'b0; hi_we = 1'b0;
        check("busy_after_ignored_start", busy, 1);
        check("hi_we_ignored_while_busy", hi, 32'hAAAA5555);
        flush = 1'b1;
        @(posedge Clock); #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        check("flush_hi", hi, 32'hAAAA5555);
        check("flush_lo", lo, vecs[14].exp_lo);
        dcnt = 0; bsy = 0;
        repeat (40) begin
            @(posedge Clock); #1;
            if (done) dcnt++;
            if (busy) bsy++;
        end
        check("no_done_after_flush", dcnt, 0);
        check("no_queued_start", bsy, 0);

        // reset mid-operation
        op = 2'd3; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        repeat (19) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_hi", hi, 0);
        check("midreset_lo", lo, 0);

        // rerun with MTLO in the accept cycle; the result overwrites it
        do_op(2'd3, 32'd100, 32'd7, 1'b1, 32'hDEADBEEF, bc);
        check("divu100_busy_cycles", bc, 34);
        check("divu100_done", done, 1);
        check("divu100_hi", hi, 32'd2);
        check("divu100_lo", lo, 32'd14);
        @(posedge Clock); #1;
        check("divu100_done_pulse", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit for the MIPS150 core.
- Executes MULT/MULTU/DIV/DIVU with a radix-2 shift-add or shift-subtract loop, and owns the architectural HI/LO registers.
- Sits beside the single-cycle ALU in EX. The pipeline reads hi/lo for MFHI/MFLO and stalls on busy.
- Generalises the ALU to a parametrised width and adds sequential, handshaked execution.

Parameters:
- WIDTH, 32: operand and HI/LO width; must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, do not override.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request an operation; accepted only when busy=0 and flush=0.
- op  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled on accept.
- A  in  WIDTH  rs operand (multiplicand / dividend); sampled on accept.
- B  in  WIDTH  rt operand (multiplier / divisor); sampled on accept.
- flush  in  1  kill the in-flight operation (branch or exception squash).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight; the pipeline stalls MFHI/MFLO/MDU ops while busy=1.
- done  out  1  one-cycle pulse; hi/lo hold the new result in this cycle.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0. Reset overrides every other input, including mid-operation.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on accept (start & ~busy & ~flush). Latch op. For signed ops, latch |A| and |B| plus the result-sign and remainder-sign bits. Counter=WIDTH.
  - RUN: one radix-2 step per cycle; counter decrements. At counter==1 -> FIX.
  - FIX: apply sign correction, write hi/lo, -> IDLE with done=1 in the following cycle.
- Latency: accept at edge 0. busy=1 from edge 0 through edge WIDTH+1. hi/lo are updated and done=1 after edge WIDTH+2, i.e. WIDTH+2 cycles, which is 34 for WIDTH=32.
- A new start is accepted in the same cycle done=1, giving back-to-back throughput of one op per WIDTH+2 cycles.
- start while busy=1: ignored, with no queueing.
- Multiply: 2*WIDTH product; {hi,lo} = product. MULT negates the product when the sign bits of A and B differ.
- Divide (restoring):
  - lo = quotient, truncated toward zero.
  - hi = remainder; its sign follows the dividend.
  - Divide by zero (B==0): lo = all-ones, hi = A. No trap; the loop still runs the full latency.
  - Signed overflow (DIV, A=MIN, B=-1): lo=MIN, hi=0.
- flush:
  - In RUN or FIX: state -> IDLE and busy=0 next cycle. hi/lo are unchanged and done is not raised.
  - In IDLE: no effect, and it blocks a simultaneous start.
- hi_we/lo_we:
  - Honoured only when busy=0.
  - Ignored while busy=1; the pipeline must not issue them then.
  - If asserted in the same cycle as an accepted start, the write takes effect and the op result overwrites it later.
- done and hi_we/lo_we are never coincident, because done only occurs with busy falling.

Decomposition:
- Shared header MDUop.vh, alongside Opcode.vh: `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU` encodings, and state encodings MDU_IDLE, MDU_RUN, MDU_FIX.
- ALUdec is extended to emit the 2-bit op from funct; that change is out of scope here.
- One sub-module, mdu_step: combinational single-iteration datapath.
  - Inputs: mode (mul/div), partial remainder/product, operand.
  - Outputs: next partial value and quotient bit.
- The top level holds the FSM, counter, sign logic and HI/LO.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Check busy=1 for exactly 34 cycles and a single-cycle done pulse.
- MULT A=0xFFFFFFF9 (-7), B=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 -> lo=3, hi=1. Issued back-to-back with start asserted in the done cycle.
- DIV A=0x12345678, B=0 -> lo=0xFFFFFFFF, hi=0x12345678. Then DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Write MTHI 0xAAAA5555 -> start MULTU 3*5. At cycle 10: pulse start (ignored), hi_we (ignored), then flush -> busy=0 next cycle, no done, hi=0xAAAA5555 retained.
- Start DIVU 100/7. Assert Reset at cycle 20 -> next cycle busy=0, done=0, hi=lo=0. Then DIVU 100/7 completes with lo=14, hi=2.
